// File: rtl/vmicro16_apb_pkg.sv
// rtl/vmicro16_apb_pkg.sv - shared FSM encoding and decode constants for the vmicro16 APB arbiter
package vmicro16_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int DEF_SEL_LSB  = 8;
  localparam int DEF_SEL_BITS = 4;

  localparam int SLV_REGS0 = 0;
  localparam int SLV_REGS1 = 1;
  localparam int SLV_REGS2 = 2;
  localparam int SLV_UART0 = 3;
  localparam int SLV_GPIO0 = 4;

endpackage

// File: rtl/vmicro16_rr_arbiter.sv
// rtl/vmicro16_rr_arbiter.sv - combinational round-robin pick starting at ptr
module vmicro16_rr_arbiter #(
  parameter int MASTERS = 2,
  parameter int PTR_W   = 1
) (
  input  logic [MASTERS-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [MASTERS-1:0] gnt,
  output logic [PTR_W-1:0]   idx
);

  int   cand;
  logic found;

  // first requester at or above ptr, wrapping modulo MASTERS
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < MASTERS; k++) begin
      cand = (int'(ptr) + k) % MASTERS;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/vmicro16_apb_arbiter.sv
// rtl/vmicro16_apb_arbiter.sv - round-robin multi-master APB arbiter with slave decode and timeout
module vmicro16_apb_arbiter
  import vmicro16_apb_pkg::*;
#(
  parameter int MASTERS   = 2,
  parameter int SLAVES    = 5,
  parameter int BUS_WIDTH = 16,
  parameter int SEL_LSB   = DEF_SEL_LSB,
  parameter int SEL_BITS  = DEF_SEL_BITS,
  parameter int TIMEOUT   = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [MASTERS*BUS_WIDTH-1:0]   S_PADDR,
  input  logic [MASTERS-1:0]             S_PWRITE,
  input  logic [MASTERS-1:0]             S_PSELx,
  input  logic [MASTERS-1:0]             S_PENABLE,
  input  logic [MASTERS*BUS_WIDTH-1:0]   S_PWDATA,
  output logic [MASTERS*BUS_WIDTH-1:0]   S_PRDATA,
  output logic [MASTERS-1:0]             S_PREADY,
  output logic [BUS_WIDTH-1:0]           M_PADDR,
  output logic                           M_PWRITE,
  output logic [SLAVES-1:0]              M_PSELx,
  output logic                           M_PENABLE,
  output logic [BUS_WIDTH-1:0]           M_PWDATA,
  input  logic [BUS_WIDTH-1:0]           M_PRDATA,
  input  logic                           M_PREADY,
  output logic                           err_timeout,
  output logic [MASTERS-1:0]             grant
);

  localparam int PTR_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  apb_state_t             state_q;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d, idx_q;
  logic [7:0]             cnt_q;
  logic [MASTERS-1:0]     grant_q;
  logic [BUS_WIDTH-1:0]   addr_q, wdata_q;
  logic                   write_q, penable_q, miss_q;
  logic [SLAVES-1:0]      psel_q, sel_d;

  logic [MASTERS-1:0]     arb_gnt;
  logic [PTR_W-1:0]       arb_idx;
  logic [BUS_WIDTH-1:0]   req_addr, req_wdata;
  logic                   req_write;
  logic [SEL_BITS-1:0]    slv_idx;
  logic                   in_access, timeout_hit, done, rd_ok;

  // the cores drive their own PENABLE, but phases are regenerated here
  logic unused_penable;
  assign unused_penable = ^S_PENABLE;

  vmicro16_rr_arbiter #(.MASTERS(MASTERS), .PTR_W(PTR_W)) u_rr (
    .req (S_PSELx),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // pick out the winning master's request and decode its slave index
  always_comb begin
    req_addr  = S_PADDR[int'(arb_idx)*BUS_WIDTH +: BUS_WIDTH];
    req_wdata = S_PWDATA[int'(arb_idx)*BUS_WIDTH +: BUS_WIDTH];
    req_write = S_PWRITE[arb_idx];
    slv_idx   = req_addr[SEL_LSB +: SEL_BITS];
    sel_d     = '0;
    for (int s = 0; s < SLAVES; s++) begin
      sel_d[s] = (slv_idx == SEL_BITS'(s));
    end
  end

  // pointer moves one past the master that just finished
  always_comb begin
    rr_ptr_d = (int'(idx_q) == MASTERS - 1) ? '0 : idx_q + 1'b1;
  end

  // completion: slave ready, decode miss (no slave will answer) or timeout
  always_comb begin
    in_access   = (state_q == ACCESS);
    timeout_hit = in_access && !miss_q && !M_PREADY && (cnt_q == TIMEOUT_CNT);
    rd_ok       = in_access && !miss_q && M_PREADY;
    done        = in_access && (M_PREADY || miss_q || timeout_hit);
    S_PREADY    = done ? grant_q : '0;
    err_timeout = timeout_hit;
    S_PRDATA    = '0;
    for (int m = 0; m < MASTERS; m++) begin
      if (rd_ok && grant_q[m]) begin
        S_PRDATA[m*BUS_WIDTH +: BUS_WIDTH] = M_PRDATA;
      end
    end
  end

  // arbitration FSM with registered shared-bus outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      penable_q <= 1'b0;
      miss_q    <= 1'b0;
      psel_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|S_PSELx) begin
            grant_q <= arb_gnt;
            idx_q   <= arb_idx;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            write_q <= req_write;
            psel_q  <= sel_d;
            miss_q  <= ~|sel_d;
            cnt_q   <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          cnt_q <= cnt_q + 8'd1;
          if (done) begin
            penable_q <= 1'b0;
            psel_q    <= '0;
            grant_q   <= '0;
            rr_ptr_q  <= rr_ptr_d;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign M_PADDR   = addr_q;
  assign M_PWDATA  = wdata_q;
  assign M_PWRITE  = write_q;
  assign M_PSELx   = psel_q;
  assign M_PENABLE = penable_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_vmicro16_apb_arbiter.sv
// tb/tb_vmicro16_apb_arbiter.sv - directed scoreboard bench for vmicro16_apb_arbiter
module tb_vmicro16_apb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] S_PADDR, S_PWDATA, S_PRDATA;
  logic [1:0]  S_PWRITE, S_PSELx, S_PENABLE, S_PREADY, grant;
  logic [15:0] M_PADDR, M_PWDATA, M_PRDATA;
  logic        M_PWRITE, M_PENABLE, M_PREADY, err_timeout;
  logic [4:0]  M_PSELx;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  typedef struct {
    logic [1:0]  rdy;
    logic [31:0] rdata;
    logic        to;
  } exp_t;
  exp_t sb[$];

  // slave model: ready after slave_wait ACCESS cycles (-1 = never)
  int          slave_wait = 0;
  int          acc_cnt = 0;
  logic [15:0] slave_rdata = '0;
  logic        addr_mix = 1'b0;

  always #5 clk = ~clk;

  vmicro16_apb_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE),
    .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY),
    .err_timeout(err_timeout), .grant(grant)
  );

  always @(posedge clk) begin
    if (M_PENABLE) acc_cnt <= acc_cnt + 1;
    else           acc_cnt <= 0;
  end
  assign M_PREADY = M_PENABLE && (|M_PSELx) && (slave_wait >= 0) && (acc_cnt == slave_wait);
  assign M_PRDATA = addr_mix ? (slave_rdata ^ M_PADDR) : slave_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] rdy, input logic [31:0] rdata, input logic to);
    exp_t e;
    e.rdy = rdy; e.rdata = rdata; e.to = to;
    sb.push_back(e);
  endtask

  // scoreboard: every completion pulse must match the oldest expectation
  always @(negedge clk) begin
    if (reset && (|S_PREADY)) begin
      exp_t e;
      if (sb.size() == 0) begin
        check("sb_unexpected_pready", {30'd0, S_PREADY}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_pready", {30'd0, S_PREADY}, {30'd0, e.rdy});
        check("sb_prdata", S_PRDATA, e.rdata);
        check("sb_err_timeout", {31'd0, err_timeout}, {31'd0, e.to});
      end
    end
  end

  initial begin
    reset = 1'b0;
    S_PADDR = '0; S_PWDATA = '0; S_PWRITE = '0; S_PSELx = '0; S_PENABLE = '0;
    #1;
    check("rst_psel", {27'd0, M_PSELx}, 32'd0);
    check("rst_penable", {31'd0, M_PENABLE}, 32'd0);
    check("rst_paddr", {16'd0, M_PADDR}, 32'd0);
    check("rst_pready", {30'd0, S_PREADY}, 32'd0);
    check("rst_prdata", S_PRDATA, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_err", {31'd0, err_timeout}, 32'd0);
    cyc();
    cyc();

    // single read from GPIO0
    reset = 1'b1;
    slave_wait = 0; slave_rdata = 16'h00A5; addr_mix = 1'b0;
    S_PADDR[15:0] = 16'h0401; S_PWRITE = 2'b00; S_PSELx = 2'b01;
    push(2'b01, 32'h0000_00A5, 1'b0);
    cyc();
    check("rd_setup_psel", {27'd0, M_PSELx}, 32'h10);
    check("rd_setup_penable", {31'd0, M_PENABLE}, 32'd0);
    check("rd_setup_grant", {30'd0, grant}, 32'd1);
    check("rd_setup_paddr", {16'd0, M_PADDR}, 32'h0401);
    S_PSELx = 2'b00;
    cyc();
    check("rd_access_penable", {31'd0, M_PENABLE}, 32'd1);
    check("rd_access_pready", {30'd0, S_PREADY}, 32'd1);
    check("rd_access_prdata", S_PRDATA, 32'h0000_00A5);
    cyc();
    check("rd_idle_grant", {30'd0, grant}, 32'd0);
    check("rd_idle_penable", {31'd0, M_PENABLE}, 32'd0);

    // reset in the middle of master1's ACCESS phase
    slave_wait = -1;
    S_PADDR[31:16] = 16'h0100; S_PSELx = 2'b10;
    cyc();
    check("rm_setup_grant", {30'd0, grant}, 32'd2);
    S_PSELx = 2'b00;
    cyc();
    check("rm_access_penable", {31'd0, M_PENABLE}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rm_penable", {31'd0, M_PENABLE}, 32'd0);
    check("rm_psel", {27'd0, M_PSELx}, 32'd0);
    check("rm_grant", {30'd0, grant}, 32'd0);
    check("rm_pready", {30'd0, S_PREADY}, 32'd0);
    check("rm_paddr", {16'd0, M_PADDR}, 32'd0);
    cyc();
    cyc();

    // contention: both masters request continuously, grants alternate from master0
    reset = 1'b1;
    slave_wait = 0; slave_rdata = 16'h5A00; addr_mix = 1'b1;
    S_PADDR = {16'h0120, 16'h0010}; S_PSELx = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push(2'b01, {16'h0000, 16'h5A10}, 1'b0);
      else            push(2'b10, {16'h5B20, 16'h0000}, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("ct_grant", {30'd0, grant}, (k % 2 == 0) ? 32'd1 : 32'd2);
      check("ct_psel", {27'd0, M_PSELx}, (k % 2 == 0) ? 32'h01 : 32'h02);
      cyc();
      check("ct_pready", {30'd0, S_PREADY}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k == 3) S_PSELx = 2'b00;
      cyc();
      check("ct_idle_grant", {30'd0, grant}, 32'd0);
    end

    // decode miss: master1 writes to an index beyond the slave count
    S_PADDR[31:16] = 16'h0700; S_PWDATA[31:16] = 16'hBEEF; S_PWRITE = 2'b10; S_PSELx = 2'b10;
    push(2'b10, 32'd0, 1'b0);
    cyc();
    check("dm_setup_psel", {27'd0, M_PSELx}, 32'd0);
    check("dm_setup_grant", {30'd0, grant}, 32'd2);
    check("dm_pwrite", {31'd0, M_PWRITE}, 32'd1);
    check("dm_pwdata", {16'd0, M_PWDATA}, 32'hBEEF);
    S_PSELx = 2'b00;
    cyc();
    check("dm_access_psel", {27'd0, M_PSELx}, 32'd0);
    check("dm_access_pready", {30'd0, S_PREADY}, 32'd2);
    check("dm_access_prdata", S_PRDATA, 32'd0);
    cyc();

    // three wait states: completion in the fourth ACCESS cycle
    slave_wait = 3; slave_rdata = 16'h1234;
    S_PADDR[15:0] = 16'h0200; S_PWRITE = 2'b00; S_PSELx = 2'b01;
    push(2'b01, {16'h0000, 16'h1034}, 1'b0);
    cyc();
    check("ws_setup_psel", {27'd0, M_PSELx}, 32'h04);
    S_PSELx = 2'b00;
    for (int j = 0; j < 3; j++) begin
      cyc();
      check("ws_wait_pready", {30'd0, S_PREADY}, 32'd0);
      check("ws_wait_penable", {31'd0, M_PENABLE}, 32'd1);
    end
    cyc();
    check("ws_done_pready", {30'd0, S_PREADY}, 32'd1);
    check("ws_done_prdata", S_PRDATA, {16'h0000, 16'h1034});
    cyc();

    // slave never answers: forced completion once 4 ACCESS cycles have elapsed
    slave_wait = -1; slave_rdata = 16'hFFFF;
    S_PADDR[31:16] = 16'h0300; S_PSELx = 2'b10;
    push(2'b10, 32'd0, 1'b1);
    cyc();
    check("to_setup_grant", {30'd0, grant}, 32'd2);
    S_PSELx = 2'b00;
    for (int j = 0; j < 4; j++) begin
      cyc();
      check("to_wait_pready", {30'd0, S_PREADY}, 32'd0);
      check("to_wait_err", {31'd0, err_timeout}, 32'd0);
    end
    cyc();
    check("to_err", {31'd0, err_timeout}, 32'd1);
    check("to_pready", {30'd0, S_PREADY}, 32'd2);
    check("to_prdata", S_PRDATA, 32'd0);
    cyc();
    check("to_idle_err", {31'd0, err_timeout}, 32'd0);
    check("to_idle_grant", {30'd0, grant}, 32'd0);

    cyc();
    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vmicro16_apb_arbiter.md
Name: vmicro16_apb_arbiter

Overview:
- Multi-master APB arbiter and address decoder for the vmicro16 SoC.
- Shares one APB slave bus (regs, UART, GPIO) between MASTERS vmicro16 cores.
- Grants one core per transfer using round-robin order and re-times that core's request into a compliant SETUP/ACCESS sequence on the shared bus.
- Decodes the slave one-hot PSELx and guards against hung slaves with a timeout.

Parameters:
- MASTERS, 2, number of core APB master ports.
- SLAVES, 5, number of slave select lines.
- BUS_WIDTH, 16, address and data width.
- SEL_LSB, 8, lowest PADDR bit of the slave index field.
- SEL_BITS, 4, width of the slave index field: index = PADDR[SEL_LSB+SEL_BITS-1:SEL_LSB].
- TIMEOUT, 255, maximum ACCESS cycles allowed before forced completion (8-bit counter).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- S_PADDR  in  MASTERS*BUS_WIDTH  per-master address; master i occupies [i*BUS_WIDTH +: BUS_WIDTH].
- S_PWRITE  in  MASTERS  per-master write flag.
- S_PSELx  in  MASTERS  per-master request.
- S_PENABLE  in  MASTERS  per-master enable; ignored, the arbiter generates phases itself.
- S_PWDATA  in  MASTERS*BUS_WIDTH  per-master write data.
- S_PRDATA  out  MASTERS*BUS_WIDTH  per-master read data.
- S_PREADY  out  MASTERS  per-master completion pulse.
- M_PADDR  out  BUS_WIDTH  shared-bus address.
- M_PWRITE  out  1  shared-bus write flag.
- M_PSELx  out  SLAVES  one-hot slave select.
- M_PENABLE  out  1  shared-bus enable.
- M_PWDATA  out  BUS_WIDTH  shared-bus write data.
- M_PRDATA  in  BUS_WIDTH  shared-bus read data.
- M_PREADY  in  1  shared-bus ready.
- err_timeout  out  1  one-cycle pulse on forced completion.
- grant  out  MASTERS  one-hot current owner; zero when idle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, counter=0.
  - All outputs are 0: M_*, S_PREADY, S_PRDATA, grant, err_timeout.
  - A transfer in flight is abandoned and no S_PREADY is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any S_PSELx bit is set, pick the first requester searching from rr_ptr upward, wrapping modulo MASTERS.
  - Register grant, S_PADDR, S_PWRITE and S_PWDATA for that master, then go to SETUP.
  - If no request is present, remain in IDLE.
- SETUP (exactly 1 cycle):
  - M_PADDR, M_PWRITE and M_PWDATA come from the latched values.
  - M_PSELx = decoded one-hot; M_PENABLE=0.
  - Next state is ACCESS.
- ACCESS:
  - M_PENABLE=1; M_PSELx, M_PADDR, M_PWRITE and M_PWDATA held stable.
  - The counter increments each cycle.
- Completion in ACCESS:
  - On M_PREADY=1, S_PREADY[grant] pulses for 1 cycle, combinationally in the same cycle.
  - S_PRDATA[grant] = M_PRDATA; the other masters' S_PRDATA lanes read 0.
  - rr_ptr = granted index + 1, wrapping to 0; go to IDLE.
- Minimum transfer is 3 cycles including the IDLE arbitration cycle. There is one IDLE turnaround cycle between consecutive transfers.
- Decode miss:
  - Applies when the slave index is >= SLAVES.
  - M_PSELx=0 throughout.
  - The arbiter completes in the first ACCESS cycle itself, with S_PREADY pulse and S_PRDATA=0.
- Timeout:
  - If the counter reaches TIMEOUT without M_PREADY, force completion: S_PREADY pulse, S_PRDATA=0, err_timeout=1 for 1 cycle.
  - The counter clears on entry to SETUP.
- Simultaneous requests: the round-robin pointer guarantees each requester is granted within MASTERS transfers.
- Master drops S_PSELx while granted: this is a protocol violation. The transfer still completes on the bus using the latched values, and the S_PREADY pulse is still issued.
- Requests from non-granted masters are held off; their S_PREADY stays 0.
- MASTERS=1 degenerates to a pass-through with the same phase timing.

Decomposition:
- Package vmicro16_apb_pkg holds:
  - the FSM state encoding (IDLE=0, SETUP=1, ACCESS=2);
  - the default decode constants (SEL_LSB, SEL_BITS);
  - the slave index constants for REGS0..2, UART0 and GPIO0 (0..4).
- Sub-module vmicro16_rr_arbiter is purely combinational.
  - Inputs: req[MASTERS-1:0], ptr.
  - Outputs: one-hot gnt and a binary index.
  - It is instantiated once.

Test Plan:
- Single read: master0 requests PADDR=16'h0401 → SETUP with M_PSELx=5'b10000 and M_PENABLE=0; the next cycle M_PENABLE=1; slave returns PRDATA=16'h00A5 with PREADY → S_PREADY[0] pulses with S_PRDATA[15:0]=16'h00A5 at cycle 3.
- Contention: both masters request every cycle after reset → grants alternate 0,1,0,1; each transfer takes 3 cycles; no master is starved.
- Decode miss: master1 writes to PADDR=16'h0700 → M_PSELx stays 0 and S_PREADY[1] pulses in the first ACCESS cycle with S_PRDATA=0.
- Wait states and timeout: slave holds PREADY=0 for 3 cycles → completion in ACCESS cycle 4. With PREADY never asserted and TIMEOUT=4 → err_timeout and S_PREADY pulse after the 4th ACCESS cycle, with PRDATA=0.
- Reset mid-ACCESS: assert reset low during ACCESS → all outputs go to 0 immediately and no S_PREADY pulse occurs; after release, the first grant goes to master0.
